// File: rtl/seg7_pkg.sv
// seg7_pkg: widths, segment pattern constants, scan FSM state type and the
// segment-to-digit decode function. Define SEG7_HEX_EN to decode A-F as well.
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;

    // Active-high segment patterns {a,b,c,d,e,f,g}, a = bit 6.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h1F;
    localparam logic [SEG_W-1:0] SEG_C = 7'h4E;
    localparam logic [SEG_W-1:0] SEG_D = 7'h3D;
    localparam logic [SEG_W-1:0] SEG_E = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_F = 7'h47;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] code;
        logic               err;
    } seg_dec_t;

    // Unknown patterns map to code F with err set; with the hex table
    // enabled code F is also a legal digit, so err is the only indicator.
    function automatic seg_dec_t seg7_decode(input logic [SEG_W-1:0] seg);
        seg_dec_t r;
        r.code = 4'h0;
        r.err  = 1'b0;
        case (seg)
            SEG_0: r.code = 4'h0;
            SEG_1: r.code = 4'h1;
            SEG_2: r.code = 4'h2;
            SEG_3: r.code = 4'h3;
            SEG_4: r.code = 4'h4;
            SEG_5: r.code = 4'h5;
            SEG_6: r.code = 4'h6;
            SEG_7: r.code = 4'h7;
            SEG_8: r.code = 4'h8;
            SEG_9: r.code = 4'h9;
`ifdef SEG7_HEX_EN
            SEG_A: r.code = 4'hA;
            SEG_B: r.code = 4'hB;
            SEG_C: r.code = 4'hC;
            SEG_D: r.code = 4'hD;
            SEG_E: r.code = 4'hE;
            SEG_F: r.code = 4'hF;
`endif
            default: begin
                r.code = 4'hF;
                r.err  = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational segment pattern -> {code, err}.
// Ports: seg_i (7 segments, a = bit 6), code_o (4-bit digit), err_o (undecodable).
// Honours SEG7_HEX_EN through seg7_pkg::seg7_decode.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]   seg_i,
    output logic [DIGIT_W-1:0] code_o,
    output logic               err_o
);

    seg_dec_t dec;

    always_comb begin
        dec    = seg7_decode(seg_i);
        code_o = dec.code;
        err_o  = dec.err;
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples multiplexed 7-segment lines and digit strobes,
// debounces each strobed digit, decodes it and emits one frame per full scan.
// Ports: clk, rst (async, active-high); seg_in[6:0], dig_en[N-1:0] (pins);
//   out_digits[4N-1:0], out_err[N-1:0], out_valid / out_ready (frame handshake);
//   frame_drop (1-cycle pulse when a completed frame is discarded).
// Build option: SEG7_HEX_EN adds A-F patterns to the decode table.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEG_W-1:0]            seg_in,
    input  logic [N_DIGITS-1:0]         dig_en,
    output logic [DIGIT_W*N_DIGITS-1:0] out_digits,
    output logic [N_DIGITS-1:0]         out_err,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        frame_drop
);

    localparam int FW    = DIGIT_W * N_DIGITS;
    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

    // Scan FSM and latched sample
    state_e              state_q;
    logic [SEG_W-1:0]    seg_q;
    logic [N_DIGITS-1:0] dig_q;
    logic [CNT_W-1:0]    cnt_q;

    // Capture slots
    logic [N_DIGITS-1:0] mask_q;
    logic [N_DIGITS-1:0] mask_d;
    logic [FW-1:0]       cap_code_q;
    logic [N_DIGITS-1:0] cap_err_q;

    // Output register
    logic [FW-1:0]       out_digits_q;
    logic [N_DIGITS-1:0] out_err_q;
    logic                out_valid_q;
    logic                frame_drop_q;

    logic                legal;
    logic                same;
    logic                wr;
    logic                full;
    logic                load;
    logic                drop;
    logic [DIGIT_W-1:0]  dec_code;
    logic                dec_err;

    // Decode works on the latched pattern, which equals seg_in whenever
    // a slot write happens (write requires an unchanged sample).
    seg7_pattern_decode u_dec (
        .seg_i  (seg_q),
        .code_o (dec_code),
        .err_o  (dec_err)
    );

    always_comb begin
        legal = $onehot(dig_en);
        same  = (seg_in == seg_q) && (dig_en == dig_q);
        wr    = (state_q == SETTLE) && legal && same
                && (cnt_q >= CNT_MAX);
        full  = &mask_q;
        load  = full && (!out_valid_q || out_ready);
        drop  = full && out_valid_q && !out_ready;
        // Completion clears the mask; a write on that edge still lands.
        mask_d = full ? '0 : mask_q;
        if (wr) begin
            mask_d = mask_d | dig_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            seg_q   <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (legal) begin
                        state_q <= SETTLE;
                        seg_q   <= seg_in;
                        dig_q   <= dig_en;
                        cnt_q   <= CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (!legal) begin
                        state_q <= IDLE;
                    end else if (!same) begin
                        seg_q <= seg_in;
                        dig_q <= dig_en;
                        cnt_q <= CNT_ONE;
                    end else if (cnt_q >= CNT_MAX) begin
                        state_q <= CAPTURED;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                CAPTURED: begin
                    // Any change costs a bubble cycle through IDLE.
                    if (!same) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q     <= '0;
            cap_code_q <= '0;
            cap_err_q  <= '0;
        end else begin
            mask_q <= mask_d;
            for (int i = 0; i < N_DIGITS; i++) begin
                if (wr && dig_q[i]) begin
                    cap_code_q[DIGIT_W*i +: DIGIT_W] <= dec_code;
                    cap_err_q[i] <= dec_err;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_digits_q <= '0;
            out_err_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            frame_drop_q <= drop;
            if (load) begin
                out_digits_q <= cap_code_q;
                out_err_q    <= cap_err_q;
                out_valid_q  <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_digits = out_digits_q;
    assign out_err    = out_err_q;
    assign out_valid  = out_valid_q;
    assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed scan scenarios plus random strobe traffic,
// every cycle compared against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int N = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [6:0]    seg_in = '0;
    logic [N-1:0]  dig_en = '0;
    logic          out_ready = 1'b1;
    logic [4*N-1:0] out_digits;
    logic [N-1:0]  out_err;
    logic          out_valid;
    logic          frame_drop;

    seg7_scan_decoder #(.N_DIGITS(N), .STABLE_CYC(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_en     (dig_en),
        .out_digits (out_digits),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_drop (frame_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] pats [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                              7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                              7'h4E, 7'h3D, 7'h4F, 7'h47};
`ifdef SEG7_HEX_EN
    localparam int NV = 16;
`else
    localparam int NV = 10;
`endif

    // Reference model: length of the current run of identical legal samples
    int         run;
    bit         done;
    logic [6:0] pseg;
    logic [N-1:0] pen;
    logic [N-1:0] m_mask;
    logic [3:0] m_code [N];
    logic [N-1:0] m_eb;
    logic [4*N-1:0] m_dig;
    logic [N-1:0] m_err;
    bit         m_valid;
    bit         m_drop;

    int acc_cnt = 0;
    int drop_cnt = 0;
    logic [4*N-1:0] acc_frame = '0;
    logic [N-1:0] acc_err = '0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_decode(input logic [6:0] s, output logic [3:0] c,
                              output logic e);
        c = 4'hF;
        e = 1'b1;
        for (int k = 0; k < NV; k++) begin
            if (pats[k] == s) begin
                c = 4'(k);
                e = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        run = 0; done = 0; pseg = '0; pen = '0; m_mask = '0;
        for (int i = 0; i < N; i++) m_code[i] = '0;
        m_eb = '0; m_dig = '0; m_err = '0; m_valid = 0; m_drop = 0;
    endtask

    task automatic model_edge(input logic [6:0] s, input logic [N-1:0] e,
                              input logic r);
        logic [3:0] c;
        logic ce;
        m_drop = 0;
        if (m_mask == '1) begin
            if (!m_valid || r) begin
                for (int i = 0; i < N; i++) m_dig[4*i +: 4] = m_code[i];
                m_err = m_eb;
                m_valid = 1;
            end else begin
                m_drop = 1;
            end
            m_mask = '0;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        if (done) begin
            if (s != pseg || e != pen) begin
                done = 0;
                run = 0;
            end
        end else if ($countones(e) != 1) begin
            run = 0;
        end else if (run > 0 && s == pseg && e == pen) begin
            run++;
            if (run > S) begin
                ref_decode(s, c, ce);
                for (int i = 0; i < N; i++) begin
                    if (e[i]) begin
                        m_code[i] = c;
                        m_eb[i] = ce;
                        m_mask[i] = 1'b1;
                    end
                end
                done = 1;
            end
        end else begin
            run = 1;
        end
        pseg = s;
        pen = e;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 16'(out_valid), 16'(m_valid));
        chk({tag, "_digits"}, out_digits, m_dig);
        chk({tag, "_err"}, 16'(out_err), 16'(m_err));
        chk({tag, "_drop"}, 16'(frame_drop), 16'(m_drop));
    endtask

    task automatic step(input logic [6:0] s, input logic [N-1:0] e,
                        input logic r, input string tag);
        seg_in = s;
        dig_en = e;
        out_ready = r;
        if (out_valid && r) begin
            acc_cnt++;
            acc_frame = out_digits;
            acc_err = out_err;
        end
        @(posedge clk);
        model_edge(s, e, r);
        #1;
        if (frame_drop) drop_cnt++;
        check_all(tag);
    endtask

    task automatic idle(input int n, input logic r, input string tag);
        for (int k = 0; k < n; k++) step(7'h00, '0, r, tag);
    endtask

    task automatic hold(input logic [6:0] s, input int d, input int n,
                        input logic r, input string tag);
        for (int k = 0; k < n; k++) step(s, N'(1) << d, r, tag);
    endtask

    // pk holds slot i pattern at [7*i +: 7]
    task automatic scan(input logic [27:0] pk, input logic r,
                        input string tag);
        for (int d = 0; d < N; d++) hold(pk[7*d +: 7], d, 6, r, tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int a0;
        int d0;
        logic [15:0] exp_f;
        logic [3:0] exp_e;
        logic [N-1:0] re;
        logic [6:0] rs;
        int len;
        logic rr;

        model_reset();
        #1;
        do_reset("reset");

        // 1: plain scan 0,1,2,3
        scan({7'h79, 7'h6D, 7'h30, 7'h7E}, 1'b1, "t1");
        idle(4, 1'b1, "t1i");
        chk("t1_count", 16'(acc_cnt), 16'd1);
        chk("t1_frame", acc_frame, 16'h3210);
        chk("t1_err", 16'(acc_err), 16'h0);

        // 2: digit 1 bounces, then settles on 8
        a0 = acc_cnt;
        hold(7'h7E, 0, 6, 1'b1, "t2");
        for (int k = 0; k < 10; k++)
            step((k % 2 == 0) ? 7'h30 : 7'h7F, 4'b0010, 1'b1, "t2b");
        hold(7'h7F, 1, 4, 1'b1, "t2s");
        chk("t2_noframe", 16'(acc_cnt - a0), 16'd0);
        hold(7'h6D, 2, 6, 1'b1, "t2");
        hold(7'h79, 3, 6, 1'b1, "t2");
        idle(4, 1'b1, "t2i");
        chk("t2_count", 16'(acc_cnt - a0), 16'd1);
        chk("t2_frame", acc_frame, 16'h3280);

        // 3: consumer stalls across two scans
        d0 = drop_cnt;
        a0 = acc_cnt;
        scan({7'h7B, 7'h70, 7'h5F, 7'h5B}, 1'b0, "t3a");
        idle(3, 1'b0, "t3h");
        scan({7'h30, 7'h30, 7'h30, 7'h30}, 1'b0, "t3b");
        idle(3, 1'b0, "t3h");
        chk("t3_drops", 16'(drop_cnt - d0), 16'd1);
        chk("t3_held", out_digits, 16'h9765);
        step(7'h00, '0, 1'b1, "t3r");
        step(7'h00, '0, 1'b1, "t3r");
        chk("t3_acc", acc_frame, 16'h9765);
        chk("t3_count", 16'(acc_cnt - a0), 16'd1);
        chk("t3_vfall", 16'(out_valid), 16'd0);

        // 4: hex pattern on digit 2
`ifdef SEG7_HEX_EN
        exp_f = 16'h3A10;
        exp_e = 4'b0000;
`else
        exp_f = 16'h3F10;
        exp_e = 4'b0100;
`endif
        scan({7'h79, 7'h77, 7'h30, 7'h7E}, 1'b1, "t4");
        idle(4, 1'b1, "t4i");
        chk("t4_frame", acc_frame, exp_f);
        chk("t4_err", 16'(acc_err), 16'(exp_e));

        // 5: illegal strobes interrupt settling of digit 3
        a0 = acc_cnt;
        hold(7'h7E, 0, 6, 1'b1, "t5");
        hold(7'h30, 1, 6, 1'b1, "t5");
        hold(7'h6D, 2, 6, 1'b1, "t5");
        hold(7'h79, 3, 2, 1'b1, "t5x");
        step(7'h79, 4'b0011, 1'b1, "t5m");
        hold(7'h79, 3, 2, 1'b1, "t5x");
        step(7'h79, 4'b0000, 1'b1, "t5z");
        hold(7'h79, 3, 3, 1'b1, "t5x");
        idle(4, 1'b1, "t5i");
        chk("t5_noframe", 16'(acc_cnt - a0), 16'd0);
        hold(7'h79, 3, 6, 1'b1, "t5");
        idle(4, 1'b1, "t5i");
        chk("t5_count", 16'(acc_cnt - a0), 16'd1);
        chk("t5_frame", acc_frame, 16'h3210);

        // 6: reset with three slots captured
        hold(7'h33, 0, 6, 1'b1, "t6");
        hold(7'h5B, 1, 6, 1'b1, "t6");
        hold(7'h5F, 2, 6, 1'b1, "t6");
        hold(7'h70, 3, 2, 1'b1, "t6");
        do_reset("t6rst");
        chk("t6_zero", out_digits, 16'h0);
        a0 = acc_cnt;
        hold(7'h70, 3, 6, 1'b1, "t6a");
        idle(4, 1'b1, "t6i");
        chk("t6_noframe", 16'(acc_cnt - a0), 16'd0);
        scan({7'h70, 7'h5F, 7'h5B, 7'h33}, 1'b1, "t6b");
        idle(4, 1'b1, "t6i");
        chk("t6_frame", acc_frame, 16'h7654);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 4) != 0)
                re = N'(1) << $urandom_range(0, N - 1);
            else
                re = N'($urandom);
            if ($urandom_range(0, 7) != 0)
                rs = pats[$urandom_range(0, 15)];
            else
                rs = 7'($urandom);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                rr = ($urandom_range(0, 3) != 0);
                step(rs, re, rr, "rnd");
            end
        end
        idle(4, 1'b1, "end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
